// File: rtl/red_pitaya_sort_scheduler.sv
// Sort actuation scheduler: timestamps FADS sort requests into a FIFO and
// drives one trigger output after a programmable delay for a programmable time.
module red_pitaya_sort_scheduler #(
  parameter int unsigned QAW = 3,
  parameter int unsigned TW  = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          enable_i,
  input  logic          flush_i,
  input  logic          merge_i,
  input  logic          req_i,
  input  logic [TW-1:0] delay_i,
  input  logic [TW-1:0] duration_i,
  input  logic [TW-1:0] min_gap_i,
  output logic          trig_o,
  output logic          busy_o,
  output logic [QAW:0]  q_level_o,
  output logic [TW-1:0] req_cnt_o,
  output logic [TW-1:0] drop_cnt_o,
  output logic [TW-1:0] fired_cnt_o,
  output logic [TW-1:0] merged_cnt_o
);

  localparam logic [TW-1:0] ONE     = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [QAW:0]  PTR_ONE = {{QAW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] now, cnt, cnt_nxt;
  logic [TW-1:0] mem [2**QAW];
  logic [QAW:0]  wr_ptr, rd_ptr;
  logic          empty, full, head_due;
  logic [TW-1:0] head, diff;
  logic          pop, merging, accept, drop, push;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[QAW] != rd_ptr[QAW]) &&
                    (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
  assign head     = mem[rd_ptr[QAW-1:0]];
  // Wrap-safe comparison: due once now has reached head within half the range.
  assign diff     = now - head;
  assign head_due = !empty && !diff[TW-1];

  assign accept = enable_i && req_i && !flush_i;
  assign drop   = accept && full && !pop;
  assign push   = accept && !drop;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    merging   = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (state == GAP && cnt > ONE) begin
          cnt_nxt = cnt - ONE;
        end else begin
          // The final gap cycle may already launch, so the output stays low
          // for exactly min_gap cycles when an entry is waiting.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (head_due) begin
            pop = 1'b1;
            if (duration_i != '0) begin
              state_nxt = PULSE;
              cnt_nxt   = duration_i;
            end
          end
        end
      end
      PULSE: begin
        if (head_due && merge_i) begin
          pop     = 1'b1;
          merging = 1'b1;
        end
        if (merging && duration_i != '0) begin
          cnt_nxt = duration_i;
        end else if (merging || cnt <= ONE) begin
          if (min_gap_i != '0) begin
            state_nxt = GAP;
            cnt_nxt   = min_gap_i;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state        <= IDLE;
      cnt          <= '0;
      now          <= '0;
      trig_o       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      req_cnt_o    <= '0;
      drop_cnt_o   <= '0;
      fired_cnt_o  <= '0;
      merged_cnt_o <= '0;
    end else begin
      now <= now + ONE;
      if (flush_i) begin
        state  <= IDLE;
        cnt    <= '0;
        trig_o <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        trig_o <= (state_nxt == PULSE);
        if (push)    wr_ptr       <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr       <= rd_ptr + PTR_ONE;
        if (push)    req_cnt_o    <= req_cnt_o + ONE;
        if (drop)    drop_cnt_o   <= drop_cnt_o + ONE;
        if (pop)     fired_cnt_o  <= fired_cnt_o + ONE;
        if (merging) merged_cnt_o <= merged_cnt_o + ONE;
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (push) mem[wr_ptr[QAW-1:0]] <= now + delay_i;
  end

  assign q_level_o = wr_ptr - rd_ptr;
  assign busy_o    = (state != IDLE) || !empty;

endmodule

// File: tb/tb_red_pitaya_sort_scheduler.sv
// Directed bench for red_pitaya_sort_scheduler; a second narrow-timestamp
// instance exercises the wrap of the timestamp counter.
module tb_red_pitaya_sort_scheduler;

  localparam int unsigned QAW = 3;
  localparam int unsigned TW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, flush = 1'b0, merge = 1'b0, req = 1'b0;
  logic [TW-1:0] delay = '0, duration = '0, min_gap = '0;
  logic          trig, busy;
  logic [QAW:0]  q_level;
  logic [TW-1:0] req_cnt, drop_cnt, fired_cnt, merged_cnt;

  logic          en_w = 1'b1, fl_w = 1'b0, mg_w = 1'b0, req_w = 1'b0;
  logic [7:0]    delay_w = 8'd40, dur_w = 8'd5, gap_w = 8'd0;
  logic          trig_w, busy_w;
  logic [QAW:0]  q_level_w;
  logic [7:0]    req_cnt_w, drop_cnt_w, fired_cnt_w, merged_cnt_w;

  red_pitaya_sort_scheduler #(.QAW(QAW), .TW(TW)) dut (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .enable_i(enable), .flush_i(flush),
    .merge_i(merge), .req_i(req), .delay_i(delay), .duration_i(duration),
    .min_gap_i(min_gap), .trig_o(trig), .busy_o(busy), .q_level_o(q_level),
    .req_cnt_o(req_cnt), .drop_cnt_o(drop_cnt), .fired_cnt_o(fired_cnt),
    .merged_cnt_o(merged_cnt)
  );

  red_pitaya_sort_scheduler #(.QAW(QAW), .TW(8)) dut_w (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .enable_i(en_w), .flush_i(fl_w),
    .merge_i(mg_w), .req_i(req_w), .delay_i(delay_w), .duration_i(dur_w),
    .min_gap_i(gap_w), .trig_o(trig_w), .busy_o(busy_w), .q_level_o(q_level_w),
    .req_cnt_o(req_cnt_w), .drop_cnt_o(drop_cnt_w), .fired_cnt_o(fired_cnt_w),
    .merged_cnt_o(merged_cnt_w)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [QAW:0] peak = '0;
  logic         hist_t [2048];
  logic         hist_b [2048];
  logic         hist_w [2048];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cyc equals the DUT timestamp while inside cycle cyc.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 2048) begin
      hist_t[cyc] = trig;
      hist_b[cyc] = busy;
      hist_w[cyc] = trig_w;
    end
    if (q_level > peak) peak = q_level;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 1'b0; flush = 1'b0; req_w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    peak = '0;
    for (int i = 0; i < 2048; i++) begin
      hist_t[i] = 1'b0; hist_b[i] = 1'b0; hist_w[i] = 1'b0;
    end
  endtask

  function automatic int ones(input int sel, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++)
      if ((sel == 0 && hist_t[i]) || (sel == 1 && hist_w[i])) n++;
    return n;
  endfunction

  function automatic int rises(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++)
      if (hist_t[i] && !hist_t[i-1]) n++;
    return n;
  endfunction

  initial begin
    // reset state
    rst_n = 1'b0;
    #2;
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_level", 64'(q_level), 64'd0);
    check("rst_cnts", 64'(req_cnt | drop_cnt | fired_cnt | merged_cnt), 64'd0);

    // single pulse
    enable = 1'b1; merge = 1'b0;
    delay = 100; duration = 50; min_gap = 0;
    do_reset();
    run_to(10); pulse_req(); run_to(170);
    check("single_pre", 64'(hist_t[110]), 64'd0);
    check("single_first", 64'(hist_t[111]), 64'd1);
    check("single_last", 64'(hist_t[160]), 64'd1);
    check("single_after", 64'(hist_t[161]), 64'd0);
    check("single_width", 64'(ones(0, 1, 170)), 64'd50);
    check("single_busy160", 64'(hist_b[160]), 64'd1);
    check("single_busy161", 64'(hist_b[161]), 64'd0);
    check("single_fired", 64'(fired_cnt), 64'd1);
    check("single_req", 64'(req_cnt), 64'd1);

    // merged pulses
    merge = 1'b1;
    do_reset();
    run_to(10); pulse_req(); run_to(30); pulse_req(); run_to(220);
    check("merge_first", 64'(hist_t[111]), 64'd1);
    check("merge_last", 64'(hist_t[180]), 64'd1);
    check("merge_after", 64'(hist_t[181]), 64'd0);
    check("merge_width", 64'(ones(0, 1, 220)), 64'd70);
    check("merge_fired", 64'(fired_cnt), 64'd2);
    check("merge_merged", 64'(merged_cnt), 64'd1);

    // serialized pulses with gap
    merge = 1'b0; min_gap = 5;
    do_reset();
    run_to(10); pulse_req(); run_to(30); pulse_req(); run_to(260);
    check("ser_end1", 64'(hist_t[160]), 64'd1);
    check("ser_gap", 64'(ones(0, 161, 165)), 64'd0);
    check("ser_start2", 64'(hist_t[166]), 64'd1);
    check("ser_end2", 64'(hist_t[215]), 64'd1);
    check("ser_after2", 64'(hist_t[216]), 64'd0);
    check("ser_width", 64'(ones(0, 1, 260)), 64'd100);
    check("ser_fired", 64'(fired_cnt), 64'd2);
    check("ser_merged", 64'(merged_cnt), 64'd0);

    // queue overflow
    delay = 1000; duration = 3; min_gap = 0;
    do_reset();
    run_to(10);
    req = 1'b1;
    repeat (10) tick();
    req = 1'b0;
    check("ovf_req", 64'(req_cnt), 64'd8);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_level", 64'(q_level), 64'd8);
    check("ovf_peak", 64'(peak), 64'd8);
    run_to(1060);
    check("ovf_pre", 64'(hist_t[1010]), 64'd0);
    check("ovf_first", 64'(hist_t[1011]), 64'd1);
    check("ovf_last", 64'(hist_t[1041]), 64'd1);
    check("ovf_tail", 64'(hist_t[1042]), 64'd0);
    check("ovf_pulses", 64'(rises(1000, 1060)), 64'd8);
    check("ovf_width", 64'(ones(0, 1000, 1060)), 64'd24);
    check("ovf_fired", 64'(fired_cnt), 64'd8);
    check("ovf_empty", 64'(q_level), 64'd0);
    check("ovf_busy", 64'(busy), 64'd0);

    // timestamp wrap on the 8-bit instance: request at now=236, delay 40
    do_reset();
    run_to(236);
    req_w = 1'b1; tick(); req_w = 1'b0;
    run_to(300);
    check("wrap_early", 64'(ones(1, 237, 276)), 64'd0);
    check("wrap_rise", 64'(hist_w[277]), 64'd1);
    check("wrap_width", 64'(ones(1, 237, 300)), 64'd5);
    check("wrap_fired", 64'(fired_cnt_w), 64'd1);

    // flush mid-pulse with three entries still queued
    delay = 100; duration = 50; min_gap = 0;
    do_reset();
    run_to(10);
    req = 1'b1;
    repeat (4) tick();
    req = 1'b0;
    run_to(120);
    check("fl_trig_pre", 64'(trig), 64'd1);
    check("fl_level_pre", 64'(q_level), 64'd3);
    flush = 1'b1; req = 1'b1;
    tick();
    flush = 1'b0; req = 1'b0;
    check("fl_trig", 64'(trig), 64'd0);
    check("fl_level", 64'(q_level), 64'd0);
    check("fl_busy", 64'(busy), 64'd0);
    run_to(400);
    check("fl_quiet", 64'(ones(0, 121, 400)), 64'd0);
    check("fl_req", 64'(req_cnt), 64'd4);
    check("fl_fired", 64'(fired_cnt), 64'd1);
    check("fl_drop", 64'(drop_cnt), 64'd0);

    // asynchronous reset mid-pulse
    delay = 10;
    do_reset();
    run_to(5); pulse_req(); run_to(30);
    check("ar_trig_pre", 64'(trig), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_trig", 64'(trig), 64'd0);
    check("ar_fired", 64'(fired_cnt), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);

    // zero duration and disabled requests
    delay = 5; duration = 0;
    do_reset();
    run_to(10); pulse_req();
    run_to(20);
    enable = 1'b0;
    pulse_req();
    enable = 1'b1;
    run_to(60);
    check("zd_quiet", 64'(ones(0, 1, 60)), 64'd0);
    check("zd_fired", 64'(fired_cnt), 64'd1);
    check("zd_req", 64'(req_cnt), 64'd1);
    check("zd_level", 64'(q_level), 64'd0);
    check("zd_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/red_pitaya_sort_scheduler.md
Name: red_pitaya_sort_scheduler

Overview:
Schedules sort actuations for the droplet sorter. Each sort request from the FADS evaluation logic is timestamped and queued. The single sort output (ASG trigger / HV amplifier gate) fires after a programmable delay for a programmable duration. Several droplets can be in flight between the detector and the sorting junction, and overlapping pulses are either merged or serialized.

Parameters:
QAW, 3, queue address width; queue depth = 2^QAW entries
TW, 32, width of timestamp, delay, duration, gap and statistics counters

Ports:
adc_clk_i  in  1  ADC clock, sole clock
adc_rstn_i  in  1  reset, asynchronous, active-low
enable_i  in  1  1 = accept new requests
flush_i  in  1  1-cycle pulse: empty queue, abort pulse
merge_i  in  1  1 = merge overlapping pulses, 0 = serialize
req_i  in  1  1-cycle sort request from FADS evaluation
delay_i  in  TW  cycles from request to pulse start; must be < 2^(TW-1)
duration_i  in  TW  pulse length in cycles
min_gap_i  in  TW  forced low cycles after each pulse
trig_o  out  1  sort trigger (registered)
busy_o  out  1  high when state != IDLE or queue non-empty
q_level_o  out  QAW+1  queue occupancy 0..2^QAW
req_cnt_o  out  TW  accepted requests
drop_cnt_o  out  TW  requests dropped because the queue was full
fired_cnt_o  out  TW  entries popped, including merged entries
merged_cnt_o  out  TW  entries absorbed into an active pulse

Behaviour:
- Reset (async, adc_rstn_i=0): all outputs 0, queue empty, state IDLE, timestamp counter now=0.
- now: free-running TW-bit counter, +1 per cycle, wraps.
- Enqueue: on req_i=1 and enable_i=1, due = now + delay_i (mod 2^TW) is written at the queue tail and req_cnt increments.
  - If the queue is full and no pop occurs in the same cycle, the request is dropped and drop_cnt increments.
  - Full with a simultaneous pop: the request is accepted and the level is unchanged.
  - enable_i=0: req_i is ignored and no counter changes. Already-queued entries still fire.
- Due test (wrap-safe): the head is due when the MSB of (now - head_due) is 0.
- Sampling points: delay_i at enqueue; duration_i at pop; min_gap_i at pulse end.
- FSM states: IDLE, PULSE, GAP.
  - IDLE, head due, duration_i>0: pop, fired_cnt+1, cnt<=duration_i, go to PULSE; trig_o=1 from the next cycle.
  - IDLE, head due, duration_i==0: pop, fired_cnt+1, no pulse, stay IDLE.
  - PULSE: trig_o=1, cnt decrements each cycle. The last cycle is cnt==1; the next state is GAP if min_gap_i>0, else IDLE.
  - PULSE, head due, merge_i=1: pop, fired_cnt+1, merged_cnt+1, cnt<=duration_i (pulse now ends duration_i cycles after the pop), trig_o stays high.
  - PULSE, head due, merge_i=0: no pop; the entry waits and fires late from IDLE.
  - GAP: trig_o=0 for exactly min_gap_i cycles, then IDLE. Due entries wait and no merging occurs.
- Latency: a request accepted at cycle t fires trig_o high at cycle t+max(delay_i,1)+1 when the FSM is idle. The pulse is exactly duration_i cycles high.
- Pops: at most one per cycle. Entries leave in FIFO order. Entries must be enqueued in nondecreasing due order (constant delay_i); a not-yet-due head blocks later entries.
- flush_i: the next cycle has queue empty, trig_o=0, state IDLE. Statistics counters are kept. A req_i in the same cycle as flush_i is discarded and not counted.
- Statistics counters wrap at 2^TW and are cleared only by reset.
- Queue pointers are QAW+1 bits wide. Full and empty are derived from the MSB and the address bits.

Test Plan:
- delay_i=100, duration_i=50, min_gap_i=0, one req at cycle 10 -> trig_o high cycles 111..160; fired_cnt=1; busy_o low from cycle 161.
- merge_i=1, delay_i=100, duration_i=50, reqs at 10 and 30 -> single pulse 111..180; fired_cnt=2, merged_cnt=1. With merge_i=0 and min_gap_i=5 -> pulses 111..160 and 166..215.
- QAW=3, delay_i=1000, 10 reqs in consecutive cycles -> req_cnt=8, drop_cnt=2, q_level_o peaks at 8; 8 pulses follow.
- Preload now to 2^32-20, delay_i=40, req -> trig_o rises 41 cycles later across the wrap, not immediately.
- flush_i mid-pulse with 3 entries queued -> trig_o=0 next cycle, q_level_o=0, no further pulses, counters unchanged. Async reset mid-pulse -> trig_o=0 immediately, without a clock edge.
- duration_i=0 with a queued entry -> trig_o never high; fired_cnt increments.
